alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit add/subtract ALU among `N_REQ` requesters. Each requester presents operands and a mode over a valid/ready handshake. The block grants one request at a time and executes it on the shared ALU. It returns a registered result, carry/borrow flag and requester ID over a valid/ready response channel. It sits between the requesting front-end logic and the single ALU instance in `top`, and it also keeps a wrapping count of completed operations.

---
 rtl/alu_pkg.sv | 7 +
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu.sv | 18 +
 rtl/alu_arbiter_rr_pick.sv | 26 ++
 rtl/alu_arbiter.sv | 55 +++++
 tb/tb_alu_arbiter.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode encodings, default width and arbiter FSM states
package alu_pkg;
  localparam int ALU_W = 8;
  localparam logic ALU_MODE_ADD = 1'b1;
  localparam logic ALU_MODE_SUB = 1'b0;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and response channels of the shared-ALU arbiter
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 8,
  parameter int IDW = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_op_a;
  logic [N_REQ*W-1:0] req_op_b;
  logic [N_REQ-1:0] req_mode;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_data;
  logic rsp_flag;
  logic [IDW-1:0] rsp_id;
  logic [7:0] done_cnt;
  modport master(
    output req_valid, req_op_a, req_op_b, req_mode, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id, done_cnt
  );
  modport slave(
    input req_valid, req_op_a, req_op_b, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id, done_cnt
  );
endinterface

// File: rtl/alu.sv
// alu: W-bit add/subtract exposing carry out (add) or borrow (subtract)
module alu import alu_pkg::*; #(
  parameter int W = ALU_W
) (
  input logic [W-1:0] a,
  input logic [W-1:0] b,
  input logic mode,
  output logic [W-1:0] y,
  output logic flag
);
  logic [W:0] sum, diff;
  // the extra bit of a zero-extended difference is set exactly when a < b
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    {flag, y} = mode == ALU_MODE_ADD ? sum : diff;
  end
endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector starting the scan at ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW = 2
) (
  input logic [N_REQ-1:0] req_valid,
  input logic [IDW-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0] idx
);
  logic [IDW-1:0] j;
  // scan from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % N_REQ);
      if (req_valid[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one add/subtract ALU with a registered response
module alu_arbiter import alu_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W = ALU_W,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  state_t state, state_nx;
  logic [IDW-1:0] ptr, idx;
  logic [N_REQ-1:0] grant;
  logic accept;
  logic [W-1:0] y;
  logic flag;
  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req_valid(bus.req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  alu #(.W(W)) u_alu (
    .a(bus.req_op_a[idx*W +: W]),
    .b(bus.req_op_b[idx*W +: W]),
    .mode(bus.req_mode[idx]),
    .y(y),
    .flag(flag)
  );
  always_comb begin
    accept = state == IDLE && |grant && !rst;
    bus.req_ready = accept ? grant : '0;
    bus.rsp_valid = state == RESP;
    state_nx = state == IDLE ? (accept ? RESP : IDLE) : (bus.rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      bus.rsp_data <= '0;
      bus.rsp_flag <= 1'b0;
      bus.rsp_id <= '0;
      bus.done_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        bus.rsp_data <= y;
        bus.rsp_flag <= flag;
        bus.rsp_id <= idx;
        ptr <= idx == IDW'(N_REQ - 1) ? '0 : idx + 1'b1;
      end
      if (state == RESP && bus.rsp_ready) bus.done_cnt <= bus.done_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for the shared-ALU round-robin arbiter
module tb_alu_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic flag;
  } rsp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_rsp = -1;
  logic hold = 1'b0;
  logic chk_gap = 1'b0;
  logic [3:0] acc;
  rsp_t sb[$];
  int exp_grant[$];
  alu_arbiter_if #(.N_REQ(4), .W(8), .IDW(2)) bus();
  alu_arbiter #(.N_REQ(4), .W(8), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [7:0] d;
    d = a - b;
    return m ? {1'b0, a} + {1'b0, b} : {a < b, d};
  endfunction
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic m);
    bus.req_op_a[i*8 +: 8] = a;
    bus.req_op_b[i*8 +: 8] = b;
    bus.req_mode[i] = m;
    bus.req_valid[i] = 1'b1;
  endtask
  task automatic observe();
    rsp_t e;
    logic [8:0] r;
    int g;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_flag", 32'(bus.rsp_flag), 32'(e.flag));
      end
      if (chk_gap && last_rsp >= 0) check("rsp_gap", cyc_n - last_rsp, 2);
      last_rsp = cyc_n;
    end
    check("rdy_onehot0", 32'($onehot0(bus.req_ready)), 1);
    if (bus.rsp_valid || rst) check("rdy_zero", 32'(bus.req_ready), 0);
    acc = bus.req_valid & bus.req_ready;
    if (acc != 0) begin
      if (exp_grant.size() == 0) check("grant_unexpected", 32'(acc), 0);
      else begin
        g = exp_grant.pop_front();
        check("grant", 32'(acc), 32'(1) << g);
        r = model(bus.req_op_a[g*8 +: 8], bus.req_op_b[g*8 +: 8], bus.req_mode[g]);
        sb.push_back('{id: 2'(g), data: r[7:0], flag: r[8]});
      end
    end
  endtask
  task automatic cyc();
    #1 observe();
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = bus.req_valid & ~acc;
    cyc_n++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 4'hf;
    sb.delete();
    exp_grant.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_valid", 32'(bus.rsp_valid), 0);
    end
    check("rst_cnt", 32'(bus.done_cnt), 0);
    check("rst_rsp", {bus.rsp_data, bus.rsp_id, bus.rsp_flag}, 0);
    rst = 1'b0;
    bus.req_valid = '0;
  endtask
  initial begin
    logic [7:0] d0;
    logic [7:0] c0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op_a = '0;
    bus.req_op_b = '0;
    bus.req_mode = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    do_reset();
    set_req(1, 8'hf0, 8'h20, 1'b1);
    exp_grant.push_back(1);
    cyc();
    check("latency", 32'(bus.rsp_valid), 1);
    check("add_data", 32'(bus.rsp_data), 32'h10);
    cyc();
    set_req(0, 8'h05, 8'h07, 1'b0);
    exp_grant.push_back(0);
    cyc();
    check("sub_borrow", {bus.rsp_data, bus.rsp_flag}, {8'hfe, 1'b1});
    cyc();
    set_req(0, 8'h07, 8'h05, 1'b0);
    exp_grant.push_back(0);
    cyc();
    check("sub_noborrow", {bus.rsp_data, bus.rsp_flag}, {8'h02, 1'b0});
    cyc();
    do_reset();
    set_req(0, 8'h80, 8'h80, 1'b1);
    set_req(1, 8'h00, 8'h01, 1'b0);
    set_req(2, 8'h7f, 8'h01, 1'b1);
    set_req(3, 8'hff, 8'hff, 1'b0);
    foreach (exp_grant[i]) exp_grant.delete();
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_grant.push_back(0);
    hold = 1'b1;
    chk_gap = 1'b1;
    last_rsp = -1;
    repeat (9) cyc();
    bus.req_valid = '0;
    hold = 1'b0;
    cyc();
    chk_gap = 1'b0;
    check("rr_cnt", 32'(bus.done_cnt), 5);
    check("rr_drain", sb.size() + exp_grant.size(), 0);
    bus.rsp_ready = 1'b0;
    set_req(2, 8'h33, 8'h44, 1'b0);
    exp_grant.push_back(2);
    cyc();
    d0 = bus.rsp_data;
    c0 = bus.done_cnt;
    set_req(3, 8'h10, 8'h0f, 1'b1);
    repeat (5) begin
      cyc();
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_stable", {bus.rsp_data, bus.rsp_id}, {d0, 2'd2});
      check("bp_cnt", 32'(bus.done_cnt), 32'(c0));
    end
    exp_grant.push_back(3);
    bus.rsp_ready = 1'b1;
    cyc();
    check("bp_release_cnt", 32'(bus.done_cnt), 32'(c0 + 8'd1));
    cyc();
    cyc();
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h01, 8'h02, 1'b1);
    exp_grant.push_back(1);
    cyc();
    check("mid_pending", 32'(bus.rsp_valid), 1);
    rst = 1'b1;
    sb.delete();
    cyc();
    rst = 1'b0;
    check("mid_drop", 32'(bus.rsp_valid), 0);
    check("mid_cnt", 32'(bus.done_cnt), 0);
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      set_req(0, 8'($urandom), 8'($urandom), 1'($urandom));
      exp_grant.push_back(0);
      cyc();
      cyc();
      if (n == 254) check("cnt_255", 32'(bus.done_cnt), 255);
    end
    check("cnt_wrap", 32'(bus.done_cnt), 0);
    check("final_drain", sb.size() + exp_grant.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
